// File: rtl/operand_seq_ctrl.sv
// operand_seq_ctrl: loads A, B and cmd registers from a byte stream, launches the ALU, returns its result.
// Latency: last input byte -> exec_start 1 cycle; exec_done -> out_valid 1 cycle.
// Backpressure: in_ready only in load states; out_valid holds out_data until out_ready.
module operand_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ld_a,
  output logic              ld_b,
  output logic              ld_cmd,
  output logic [DATA_W-1:0] reg_d,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic [DATA_W-1:0] res_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_CMD,
    EXEC,
    WAIT_DONE,
    OUTPUT
  } state_t;

  // Count value at which the next idle WAIT_DONE cycle is the TIMEOUT-th one.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       cmd_ok;

  // Ready and busy are pure decodes of the state register, so neither
  // depends combinationally on in_valid.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_CMD);
  assign busy     = (state != LOAD_A);

  // Only command bytes with a zero top field are accepted.
  assign cmd_ok = (in_data[DATA_W-1 -: 3] == 3'b000);

  // Sequencer: state, one-cycle strobes, register data, result holding and timeout count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      ld_a       <= 1'b0;
      ld_b       <= 1'b0;
      ld_cmd     <= 1'b0;
      reg_d      <= '0;
      exec_start <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      // Strobes and pulses are single-cycle unless re-armed below.
      ld_a       <= 1'b0;
      ld_b       <= 1'b0;
      ld_cmd     <= 1'b0;
      exec_start <= 1'b0;
      err        <= 1'b0;

      case (state)
        LOAD_A: begin
          if (in_valid) begin
            reg_d <= in_data;
            ld_a  <= 1'b1;
            state <= LOAD_B;
          end
        end

        LOAD_B: begin
          if (in_valid) begin
            reg_d <= in_data;
            ld_b  <= 1'b1;
            state <= LOAD_CMD;
          end
        end

        LOAD_CMD: begin
          if (in_valid) begin
            reg_d <= in_data;
            if (cmd_ok) begin
              // Start coincides with ld_cmd so the datapath sees the
              // command on the same edge it captures it.
              ld_cmd     <= 1'b1;
              exec_start <= 1'b1;
              state      <= EXEC;
            end else begin
              err   <= 1'b1;
              state <= LOAD_A;
            end
          end
        end

        EXEC: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (exec_done) begin
            out_data  <= res_data;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == CNT_LAST) begin
              err   <= 1'b1;
              state <= LOAD_A;
            end
          end
        end

        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end

        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Bench for operand_seq_ctrl: directed scenarios plus randomized transactions.
// Expected behaviour comes from a per-transaction timeline built from the operating rules.
// Inputs are driven and outputs checked 1 time unit after each rising edge.
module tb_operand_seq_ctrl;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ld_a, ld_b, ld_cmd;
  logic [DATA_W-1:0] reg_d;
  logic              exec_start;
  logic              exec_done;
  logic [DATA_W-1:0] res_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  // Model of the held values: last accepted byte and last captured result.
  logic [7:0] last_byte = 8'h00;
  logic [7:0] last_res  = 8'h00;

  operand_seq_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ld_a       (ld_a),
    .ld_b       (ld_b),
    .ld_cmd     (ld_cmd),
    .reg_d      (reg_d),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .res_data   (res_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected values for this cycle.
  task automatic expect_cyc(input string ph, input bit la, input bit lb, input bit lc,
                            input bit es, input bit er, input bit ov, input bit ir,
                            input bit bz);
    chk({ph, ".ld_a"},       32'(ld_a),       32'(la));
    chk({ph, ".ld_b"},       32'(ld_b),       32'(lb));
    chk({ph, ".ld_cmd"},     32'(ld_cmd),     32'(lc));
    chk({ph, ".exec_start"}, 32'(exec_start), 32'(es));
    chk({ph, ".err"},        32'(err),        32'(er));
    chk({ph, ".out_valid"},  32'(out_valid),  32'(ov));
    chk({ph, ".in_ready"},   32'(in_ready),   32'(ir));
    chk({ph, ".busy"},       32'(busy),       32'(bz));
    chk({ph, ".reg_d"},      32'(reg_d),      32'(last_byte));
    chk({ph, ".out_data"},   32'(out_data),   32'(last_res));
  endtask

  // One full transaction starting in the idle (A-loading) state.
  // d: WAIT_DONE cycle on which exec_done rises (0 or >TIMEOUT = never).
  // rst_k: WAIT_DONE cycle on which reset is pulsed (0 = none).
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] r, input int d, input int stall,
                         input int rst_k, input int gmax);
    logic [7:0] bytes [3];
    bit         got_done;
    bytes[0] = a;
    bytes[1] = b;
    bytes[2] = c;
    got_done = 1'b0;

    for (int i = 0; i < 3; i++) begin
      int gaps;
      gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      repeat (gaps) begin
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        out_ready = 1'($urandom);
        exec_done = 1'($urandom);
        tick();
        expect_cyc("gap", 0, 0, 0, 0, 0, 0, 1, i != 0);
      end
      in_valid  = 1'b1;
      in_data   = bytes[i];
      out_ready = 1'($urandom);
      exec_done = 1'($urandom);
      tick();
      in_valid  = 1'b0;
      exec_done = 1'b0;
      last_byte = bytes[i];
      if (i == 0) expect_cyc("byte_a", 1, 0, 0, 0, 0, 0, 1, 1);
      else if (i == 1) expect_cyc("byte_b", 0, 1, 0, 0, 0, 0, 1, 1);
      else if (c[7:5] == 3'b000) expect_cyc("cmd_ok", 0, 0, 1, 1, 0, 0, 0, 1);
      else begin
        expect_cyc("cmd_bad", 0, 0, 0, 0, 1, 0, 1, 0);
        return;
      end
    end

    // EXEC cycle: exec_done here must be ignored.
    exec_done = 1'($urandom);
    res_data  = 8'($urandom);
    out_ready = 1'($urandom);
    tick();

    for (int k = 1; k <= TIMEOUT; k++) begin
      // Now inside WAIT_DONE cycle k.
      expect_cyc("wait", 0, 0, 0, 0, 0, 0, 0, 1);
      if (k == rst_k) begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n     = 1'b1;
        last_byte = 8'h00;
        last_res  = 8'h00;
        expect_cyc("mid_rst", 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        expect_cyc("post_rst", 0, 0, 0, 0, 0, 0, 1, 0);
        return;
      end
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      out_ready = 1'($urandom);
      if (k == d) begin
        exec_done = 1'b1;
        res_data  = r;
        tick();
        exec_done = 1'b0;
        in_valid  = 1'b0;
        last_res  = r;
        expect_cyc("done", 0, 0, 0, 0, 0, 1, 0, 1);
        got_done = 1'b1;
        break;
      end
      exec_done = 1'b0;
      res_data  = 8'($urandom);
      tick();
      in_valid = 1'b0;
      if (k == TIMEOUT) begin
        expect_cyc("timeout", 0, 0, 0, 0, 1, 0, 1, 0);
        return;
      end
    end
    if (!got_done) return;

    repeat (stall) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      exec_done = 1'($urandom);
      tick();
      expect_cyc("stall", 0, 0, 0, 0, 0, 1, 0, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    exec_done = 1'b0;
    tick();
    out_ready = 1'b0;
    expect_cyc("out_hs", 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    exec_done = 1'b0;
    res_data  = 8'h00;
    out_ready = 1'b0;

    // Reset held for two edges with a pending byte.
    tick();
    expect_cyc("reset1", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    expect_cyc("reset2", 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    expect_cyc("post_reset", 0, 0, 0, 0, 0, 0, 1, 0);

    // Directed scenarios.
    run_txn(8'h3C, 8'h05, 8'h0A, 8'h41, 3, 0, 0, 0);
    run_txn(8'h3C, 8'h05, 8'h0A, 8'h41, 3, 4, 0, 0);
    run_txn(8'h11, 8'h22, 8'h2A, 8'h00, 1, 0, 0, 0);
    run_txn(8'h77, 8'h88, 8'h03, 8'h99, 0, 0, 0, 0);
    run_txn(8'h12, 8'h34, 8'h1F, 8'h5A, TIMEOUT, 1, 0, 0);
    run_txn(8'hA5, 8'h5A, 8'h01, 8'hC3, 0, 0, 5, 0);
    run_txn(8'h01, 8'h02, 8'h04, 8'hE7, 1, 0, 0, 0);

    // Randomized transactions.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] c;
      if ($urandom_range(0, 3) != 0) c = {3'b000, 5'($urandom)};
      else c = {3'($urandom_range(1, 7)), 5'($urandom)};
      run_txn(8'($urandom), 8'($urandom), c, 8'($urandom),
              int'($urandom_range(1, TIMEOUT + 2)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
